// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and data-memory wait handling.
// Optional memory timeout/abort path enabled by defining HAZARD_CTRL_TIMEOUT_EN.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] if_id_rs1_i,
    input  logic [4:0] if_id_rs2_i,
    input  logic       id_ex_memread_i,
    input  logic [4:0] id_ex_rd_i,
    input  logic       branch_taken_i,
    input  logic       mem_req_i,
    input  logic       mem_ack_i,
    output logic       pc_write_o,
    output logic       if_id_stall_o,
    output logic       if_id_flush_o,
    output logic       id_ex_stall_o,
    output logic       id_ex_flush_o,
    output logic       ex_mem_stall_o,
    output logic       ex_mem_flush_o,
    output logic       mem_wb_stall_o,
    output logic       mem_wb_flush_o,
`ifdef HAZARD_CTRL_TIMEOUT_EN
    output logic       timeout_o,
`endif
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ABORT    = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_t;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("hazard_ctrl: TIMEOUT_CYCLES must be within 2..255");
    end

    state_t state;
    state_t state_nxt;
    logic   load_use;
    logic   mem_stall;

    assign load_use = id_ex_memread_i && (id_ex_rd_i != 5'd0) &&
                      ((id_ex_rd_i == if_id_rs1_i) || (id_ex_rd_i == if_id_rs2_i));

    // Once in MEM_WAIT only the ack releases the pipe; a dropped request keeps it held.
    always_comb begin
        case (state)
            ST_RUN:      mem_stall = mem_req_i && !mem_ack_i;
            ST_MEM_WAIT: mem_stall = !mem_ack_i;
            default:     mem_stall = 1'b0;
        endcase
    end

`ifdef HAZARD_CTRL_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    logic       timeout_hit;

    assign timeout_hit = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_nxt = ST_RUN;
`ifdef HAZARD_CTRL_TIMEOUT_EN
        wait_cnt_nxt = 8'd0;
`endif
        case (state)
            ST_RUN: begin
                if (mem_stall) state_nxt = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (!mem_ack_i) begin
`ifdef HAZARD_CTRL_TIMEOUT_EN
                    if (timeout_hit) begin
                        state_nxt = ST_ABORT;
                    end else begin
                        state_nxt    = ST_MEM_WAIT;
                        wait_cnt_nxt = (wait_cnt == 8'hff) ? wait_cnt : wait_cnt + 8'd1;
                    end
`else
                    state_nxt = ST_MEM_WAIT;
`endif
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!rst_i) begin
            state <= ST_RUN;
`ifdef HAZARD_CTRL_TIMEOUT_EN
            wait_cnt <= 8'd0;
`endif
        end else begin
            state <= state_nxt;
`ifdef HAZARD_CTRL_TIMEOUT_EN
            wait_cnt <= wait_cnt_nxt;
`endif
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        pc_write_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        ex_mem_flush_o = 1'b0;
        mem_wb_stall_o = 1'b0;
        mem_wb_flush_o = 1'b0;
`ifdef HAZARD_CTRL_TIMEOUT_EN
        timeout_o      = 1'b0;
`endif
        if (rst_i) begin
            if (state == ST_ABORT) begin
                if_id_flush_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
                ex_mem_flush_o = 1'b1;
                mem_wb_flush_o = 1'b1;
`ifdef HAZARD_CTRL_TIMEOUT_EN
                timeout_o      = 1'b1;
`endif
            end else if (mem_stall) begin
                // Freeze everything up to MEM and bubble WB while memory is busy.
                if_id_stall_o  = 1'b1;
                id_ex_stall_o  = 1'b1;
                ex_mem_stall_o = 1'b1;
                mem_wb_flush_o = 1'b1;
            end else if (load_use) begin
                if_id_stall_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
            end else begin
                pc_write_o     = 1'b1;
                if_id_flush_o  = branch_taken_i;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; timeout vectors run when HAZARD_CTRL_TIMEOUT_EN is defined.
module tb_hazard_ctrl;

    // Output vector order: pc_write, if_id_{stall,flush}, id_ex_{stall,flush},
    // ex_mem_{stall,flush}, mem_wb_{stall,flush}.
    localparam logic [8:0] O_RESET  = 9'b000000000;
    localparam logic [8:0] O_IDLE   = 9'b100000000;
    localparam logic [8:0] O_LOAD   = 9'b010010000;
    localparam logic [8:0] O_BRANCH = 9'b101000000;
    localparam logic [8:0] O_MEM    = 9'b010101001;
    localparam logic [8:0] O_ABORT  = 9'b001010101;

    logic       clk;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       memread, branch_taken, mem_req, mem_ack;
    logic       pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic       ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush;
    logic [1:0] state;
    logic       timeout;
    logic [8:0] obs_out;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .if_id_rs1_i     (rs1),
        .if_id_rs2_i     (rs2),
        .id_ex_memread_i (memread),
        .id_ex_rd_i      (rd),
        .branch_taken_i  (branch_taken),
        .mem_req_i       (mem_req),
        .mem_ack_i       (mem_ack),
        .pc_write_o      (pc_write),
        .if_id_stall_o   (if_id_stall),
        .if_id_flush_o   (if_id_flush),
        .id_ex_stall_o   (id_ex_stall),
        .id_ex_flush_o   (id_ex_flush),
        .ex_mem_stall_o  (ex_mem_stall),
        .ex_mem_flush_o  (ex_mem_flush),
        .mem_wb_stall_o  (mem_wb_stall),
        .mem_wb_flush_o  (mem_wb_flush),
`ifdef HAZARD_CTRL_TIMEOUT_EN
        .timeout_o       (timeout),
`endif
        .state_o         (state)
    );

`ifndef HAZARD_CTRL_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

    assign obs_out = {pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                      ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic mr, input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic br, input logic rq, input logic ak);
        memread = mr; rd = d; rs1 = s1; rs2 = s2;
        branch_taken = br; mem_req = rq; mem_ack = ak;
    endtask

    // Check the combinational outputs mid-cycle, then advance past the next edge.
    task automatic cyc(input string tag, input logic [8:0] exp_out, input logic [1:0] exp_st,
                       input logic exp_to);
        @(negedge clk);
        check({tag, ".out"}, 32'(obs_out), 32'(exp_out));
        check({tag, ".state"}, 32'(state), 32'(exp_st));
`ifdef HAZARD_CTRL_TIMEOUT_EN
        check({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
`else
        if (exp_to) check({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        set_in(1, 5, 5, 0, 1, 1, 0);
        cyc("reset", O_RESET, 2'd0, 1'b0);
        rst = 1'b1;

        set_in(0, 0, 0, 0, 0, 0, 0);  cyc("idle",          O_IDLE,   2'd0, 1'b0);
        set_in(1, 5, 5, 0, 0, 0, 0);  cyc("load_use_rs1",  O_LOAD,   2'd0, 1'b0);
        set_in(0, 5, 5, 0, 0, 0, 0);  cyc("load_use_gone", O_IDLE,   2'd0, 1'b0);
        set_in(1, 0, 0, 0, 0, 0, 0);  cyc("rd_zero",       O_IDLE,   2'd0, 1'b0);
        set_in(1, 7, 3, 7, 0, 0, 0);  cyc("load_use_rs2",  O_LOAD,   2'd0, 1'b0);
        set_in(1, 7, 3, 4, 0, 0, 0);  cyc("no_match",      O_IDLE,   2'd0, 1'b0);
        set_in(1, 9, 9, 0, 1, 0, 0);  cyc("lu_beats_br",   O_LOAD,   2'd0, 1'b0);
        set_in(0, 9, 9, 0, 1, 0, 0);  cyc("branch_after",  O_BRANCH, 2'd0, 1'b0);
        set_in(1, 2, 0, 2, 0, 1, 1);  cyc("req_ack_lu",    O_LOAD,   2'd0, 1'b0);

        // Memory wait: ack low three cycles then high, request dropped mid-wait.
        set_in(1, 2, 2, 0, 1, 1, 0);  cyc("mw_entry",      O_MEM,    2'd0, 1'b0);
        set_in(0, 0, 0, 0, 0, 1, 0);  cyc("mw_wait1",      O_MEM,    2'd1, 1'b0);
        set_in(0, 0, 0, 0, 0, 0, 0);  cyc("mw_req_drop",   O_MEM,    2'd1, 1'b0);
        set_in(0, 0, 0, 0, 1, 1, 1);  cyc("mw_ack_br",     O_BRANCH, 2'd1, 1'b0);
        set_in(0, 0, 0, 0, 0, 0, 0);  cyc("mw_back_run",   O_IDLE,   2'd0, 1'b0);

        // Reset asserted while waiting on memory.
        set_in(0, 0, 0, 0, 0, 1, 0);  cyc("rw_entry",      O_MEM,    2'd0, 1'b0);
                                      cyc("rw_wait",       O_MEM,    2'd1, 1'b0);
        rst = 1'b0;                   cyc("rw_rst_low",    O_RESET,  2'd1, 1'b0);
                                      cyc("rw_rst_after",  O_RESET,  2'd0, 1'b0);
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);  cyc("rw_release",    O_IDLE,   2'd0, 1'b0);

`ifdef HAZARD_CTRL_TIMEOUT_EN
        set_in(0, 0, 0, 0, 0, 1, 0);  cyc("to_entry",      O_MEM,    2'd0, 1'b0);
        for (int i = 0; i < 4; i++) cyc("to_wait",         O_MEM,    2'd1, 1'b0);
        set_in(0, 0, 0, 0, 0, 0, 0);  cyc("to_abort",      O_ABORT,  2'd2, 1'b1);
                                      cyc("to_run",        O_IDLE,   2'd0, 1'b0);

        // Counter restarts after a reset mid-wait; an ack on the last cycle wins.
        set_in(0, 0, 0, 0, 0, 1, 0);  cyc("tr_entry",      O_MEM,    2'd0, 1'b0);
        for (int i = 0; i < 2; i++) cyc("tr_wait",         O_MEM,    2'd1, 1'b0);
        rst = 1'b0;                   cyc("tr_rst",        O_RESET,  2'd1, 1'b0);
        rst = 1'b1;                   cyc("tr_reentry",    O_MEM,    2'd0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("tr_wait2",        O_MEM,    2'd1, 1'b0);
        set_in(0, 0, 0, 0, 0, 1, 1);  cyc("tr_last_ack",   O_IDLE,   2'd1, 1'b0);
        set_in(0, 0, 0, 0, 0, 0, 0);  cyc("tr_run",        O_IDLE,   2'd0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
